mtsp_alu_add_wb: RTL

//  Write-back stage downstream of the MTSP FP/INT adder (3-cycle: SM, EX0, EX1).

---
 rtl/mtsp_wb_pkg.sv | 25 ++
 rtl/mtsp_wb_fifo.sv | 58 +++++
 rtl/mtsp_alu_add_wb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mtsp_wb_pkg.sv
// Shared types for the MTSP adder write-back stage: queued result entry and tag-pipe record.
package mtsp_wb_pkg;

   // Word width of the adder datapath (the `RANGE_DWORD width of the MTSP core).
   localparam int DATA_W    = 32;
   localparam int WB_DEST_W = 6;

   typedef struct packed {
      logic                 phase;
      logic [WB_DEST_W-1:0] dest;
      logic [DATA_W-1:0]    data;
   } wb_entry_t;

   typedef struct packed {
      logic                 v;
      logic                 ph;
      logic [WB_DEST_W-1:0] dest;
   } tag_t;

   // Phase enable the adder should present when this tag reaches the end of the pipe.
   function automatic logic [1:0] exp_phase_en(input tag_t t);
      return {t.v & t.ph, t.v & ~t.ph};
   endfunction

endpackage

// File: rtl/mtsp_wb_fifo.sv
// Circular result queue of wb_entry_t with occupancy count; push on full is ignored unless a pop
// happens in the same cycle.
module mtsp_wb_fifo
   import mtsp_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             i_push,
   input  logic             i_pop,
   input  wb_entry_t        i_entry,
   output wb_entry_t        o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mtsp_alu_add_wb.sv
// Write-back stage for the MTSP adder: tag delay pipe, tag/enable cross-check, result queue,
// credit stall. Optional same-cycle bypass when MTSP_ALU_ADD_WB_BYPASS_EN is defined.
module mtsp_alu_add_wb
   import mtsp_wb_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DEST_W  = WB_DEST_W,
   parameter int LATENCY = 3
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [1:0]        ISSUE_EN,
   input  logic [DEST_W-1:0] ISSUE_DEST0,
   input  logic [DEST_W-1:0] ISSUE_DEST1,
   input  logic [1:0]        ALU_PHASE_EN,
   input  logic [DATA_W-1:0] ALU_DOUT,
   output logic              WB_VALID,
   input  logic              WB_READY,
   output logic              WB_PHASE,
   output logic [DEST_W-1:0] WB_DEST,
   output logic [DATA_W-1:0] WB_DATA,
   output logic              ISSUE_STALL,
   output logic              OVERFLOW,
   output logic              TAG_ERR,
   input  logic              CLR_ERR
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int INF_W = $clog2(LATENCY + 1);
   localparam int SUM_W = CNT_W + INF_W;

   tag_t             r_tag [LATENCY];
   tag_t             w_tag_in;
   tag_t             w_tag_out;
   logic             w_tag_mis;
   logic             w_push;
   logic             w_fifo_push;
   logic             w_fifo_pop;
   logic             w_ovf_evt;
   wb_entry_t        w_entry;
   wb_entry_t        w_head;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic [INF_W-1:0] w_inflight;
   logic [SUM_W-1:0] w_credit;
   logic             r_overflow;
   logic             r_tag_err;

   // Phase #1 wins when both phases issue, matching the adder's own arbitration.
   assign w_tag_in.v    = |ISSUE_EN;
   assign w_tag_in.ph   = ISSUE_EN[1];
   assign w_tag_in.dest = ISSUE_EN[1] ? ISSUE_DEST1 : ISSUE_DEST0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= w_tag_in;
         for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign w_tag_out     = r_tag[LATENCY-1];
   assign w_tag_mis     = (exp_phase_en(w_tag_out) != ALU_PHASE_EN);
   assign w_push        = |ALU_PHASE_EN;
   assign w_entry.phase = ALU_PHASE_EN[1];
   assign w_entry.dest  = w_tag_out.dest;
   assign w_entry.data  = ALU_DOUT;

`ifdef MTSP_ALU_ADD_WB_BYPASS_EN
   logic w_bypass;
   assign w_bypass    = w_empty & w_push & WB_READY;
   assign w_fifo_push = w_push & ~w_bypass;
   assign w_fifo_pop  = ~w_empty & WB_READY;
   assign WB_VALID    = ~w_empty | w_bypass;
   assign WB_PHASE    = w_bypass ? w_entry.phase : w_head.phase;
   assign WB_DEST     = w_bypass ? w_entry.dest  : w_head.dest;
   assign WB_DATA     = w_bypass ? w_entry.data  : w_head.data;
`else
   assign w_fifo_push = w_push;
   assign w_fifo_pop  = ~w_empty & WB_READY;
   assign WB_VALID    = ~w_empty;
   assign WB_PHASE    = w_head.phase;
   assign WB_DEST     = w_head.dest;
   assign WB_DATA     = w_head.data;
`endif

   mtsp_wb_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .i_push  (w_fifo_push),
      .i_pop   (w_fifo_pop),
      .i_entry (w_entry),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Credit check uses registered state only, so the dispatcher sees no input-to-stall path.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight + INF_W'(r_tag[i].v);
   end

   assign w_credit    = SUM_W'(w_count) + SUM_W'(w_inflight);
   assign ISSUE_STALL = (w_credit >= SUM_W'(DEPTH));

   assign w_ovf_evt = w_fifo_push & w_full & ~w_fifo_pop;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_overflow <= 1'b0;
         r_tag_err  <= 1'b0;
      end else begin
         if (w_ovf_evt)    r_overflow <= 1'b1;
         else if (CLR_ERR) r_overflow <= 1'b0;
         if (w_tag_mis)    r_tag_err  <= 1'b1;
         else if (CLR_ERR) r_tag_err  <= 1'b0;
      end
   end

   assign OVERFLOW = r_overflow;
   assign TAG_ERR  = r_tag_err;

endmodule
